// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, opcode enum and FSM state enum
//               for the sequential ALU (seq_alu) and its add/sub unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings as presented on the op port
    localparam logic [2:0] OPC_AND  = 3'b000;
    localparam logic [2:0] OPC_OR   = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_SUB  = 3'b011;
    localparam logic [2:0] OPC_SLT  = 3'b100;
    localparam logic [2:0] OPC_MUL  = 3'b101;
    localparam logic [2:0] OPC_ILL6 = 3'b110;
    localparam logic [2:0] OPC_ILL7 = 3'b111;

    typedef enum logic [2:0] {
        OP_AND  = OPC_AND,
        OP_OR   = OPC_OR,
        OP_ADD  = OPC_ADD,
        OP_SUB  = OPC_SUB,
        OP_SLT  = OPC_SLT,
        OP_MUL  = OPC_MUL,
        OP_ILL6 = OPC_ILL6,
        OP_ILL7 = OPC_ILL7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : alu_addsub
// Description : Combinational WIDTH-bit adder/subtractor. SUB is computed as
//               a + ~b + 1. Shared by ADD, SUB and SLT.
// Ports       : a, b      - operands
//               sub       - 1 selects subtraction
//               sum       - low WIDTH bits of the result
//               carry_out - bit WIDTH of the WIDTH+1-bit sum
//               overflow  - signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    assign b_eff    = sub ? ~b : b;
    assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    assign sum       = full_sum[WIDTH-1:0];
    assign carry_out = full_sum[WIDTH];
    // Operands of equal sign producing a result of the other sign
    assign overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (full_sum[WIDTH-1] != a[WIDTH-1]);

endmodule : alu_addsub
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Registered ALU with valid/ready handshake, status flags, SLT
//               and an optional iterative shift-add multiplier. One operation
//               in flight; the result is held until consumed.
// Config      : ALU_MUL_EN - when defined, the MUL state and multiplier
//               datapath are built; otherwise op 101 reports illegal.
// Ports       : clk, reset (sync, active-high)
//               in_valid/in_ready, a, b, op      - request side
//               out_valid/out_ready, result,
//               carry_out, overflow, zero, illegal - response side
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    state_t           state;
    state_t           state_next;
    op_t              op_in;
    logic             load_alu;
    logic             start_mul;
    logic             is_mul;

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic             as_sub;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_ill;

    assign op_in     = op_t'(op);
    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);

    // SLT is derived from a - b, so everything except ADD subtracts
    assign as_sub = (op_in != OP_ADD);

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (as_sub),
        .sum      (as_sum),
        .carry_out(as_carry),
        .overflow (as_ovf)
    );

    // Single-cycle operations, evaluated on the live inputs at acceptance
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (op_in)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD, OP_SUB: begin
                alu_res   = as_sum;
                alu_carry = as_carry;
                alu_ovf   = as_ovf;
            end
            // Signed less-than: sign of (a - b) corrected by overflow
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [CNT_W-1:0]   mul_count;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic               mul_done;

    assign is_mul   = (op_in == OP_MUL);
    // One extra cycle after the last iteration to register the product
    assign mul_done = (state == MUL) && (mul_count == CNT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_count  <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else if (start_mul) begin
            mul_count  <= '0;
            mul_acc    <= '0;
            mul_mcand  <= {{WIDTH{1'b0}}, a};
            mul_mplier <= b;
        end else if ((state == MUL) && !mul_done) begin
            if (mul_mplier[0]) begin
                mul_acc <= mul_acc + mul_mcand;
            end
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_count  <= mul_count + CNT_W'(1);
        end
    end
`else
    logic mul_done;

    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        state_next = state;
        load_alu   = 1'b0;
        start_mul  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
                        start_mul  = 1'b1;
                        state_next = MUL;
                    end else begin
                        load_alu   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and flag registers, held stable while in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (load_alu) begin
            result    <= alu_res;
            carry_out <= alu_carry;
            overflow  <= alu_ovf;
            zero      <= (alu_res == '0);
            illegal   <= alu_ill;
        end
`ifdef ALU_MUL_EN
        else if (mul_done) begin
            result    <= mul_acc[WIDTH-1:0];
            carry_out <= 1'b0;
            overflow  <= |mul_acc[2*WIDTH-1:WIDTH];
            zero      <= (mul_acc[WIDTH-1:0] == '0);
            illegal   <= 1'b0;
        end
`endif
    end

endmodule : seq_alu
`default_nettype wire
